sprite_rom_arbiter: RTL and testbench

Shares the single-port on-chip sprite ROM (18-bit address space holding both background maps and all sprite sheets) between the background address generator and the sprite address generators. Each cycle it grants at most one requester, drives the ROM address, and tracks the ROM read latency so each returned palette index is tagged back to the requester that issued it. It sits between the address generators and the ROM, upstream of the color mapper.

---
 rtl/sprite_pkg.sv | 15 +
 rtl/rr_pick.sv | 41 ++++
 rtl/sprite_rom_arbiter.sv | 110 +++++++++++
 tb/tb_sprite_rom_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite ROM address/data types and requester indices
package sprite_pkg;

    localparam int SPRITE_ADDR_W = 18;
    localparam int PALETTE_W     = 4;

    // Requester slots on the sprite ROM arbiter; the background generator is always slot 0.
    localparam int REQ_BG      = 0;
    localparam int REQ_PLAYER0 = 1;
    localparam int REQ_PLAYER1 = 2;
    localparam int REQ_PLAYER2 = 3;

    typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker over a masked request vector
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    input  logic [N-1:0]     mask_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // One extra bit so ptr + offset can exceed N before wrapping back.
    localparam int SW = IDX_W + 1;

    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] cand;

    // Walk candidates starting at ptr, wrapping modulo N; first eligible one wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + SW'(i);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!any_o && req_i[cand] && mask_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - shares the sprite ROM between address generators and tags returned data
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ROM_LAT = 2,
    parameter int DATA_W  = PALETTE_W,
    parameter int BG_PRIO = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_i,
    input  sprite_addr_t [N_REQ-1:0] req_addr_i,
    output logic [N_REQ-1:0]         gnt_o,
    output sprite_addr_t             rom_addr_o,
    input  logic [DATA_W-1:0]        rom_data_i,
    output logic [N_REQ-1:0]         rd_valid_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // With background priority, slot 0 sits outside the round-robin set.
    localparam logic [IDX_W-1:0] RR_LO   = (BG_PRIO != 0) ? IDX_W'(1) : '0;
    localparam logic [N_REQ-1:0] RR_MASK = (BG_PRIO != 0) ? ~N_REQ'(1) : '1;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    sprite_addr_t     rom_addr_q, rom_addr_d;
    logic [N_REQ-1:0] rr_gnt;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_any;
    logic             strict;
    logic [N_REQ-1:0] gnt_d;
    logic [IDX_W-1:0] win_idx;
    logic             grant_any;

    // Tag pipeline: stage 0 lines up with rom_addr, stage ROM_LAT with the registered read data.
    logic [ROM_LAT:0]             tag_vld_q;
    logic [ROM_LAT:0][N_REQ-1:0]  tag_id_q;
    logic [DATA_W-1:0]            rd_data_q;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i  (req_i),
        .ptr_i  (rr_ptr_q),
        .mask_i (RR_MASK),
        .gnt_o  (rr_gnt),
        .idx_o  (rr_idx),
        .any_o  (rr_any)
    );

    // Winner selection, pointer advance and ROM address mux; nothing is granted while in reset.
    always_comb begin
        strict     = (BG_PRIO != 0) && req_i[REQ_BG];
        gnt_d      = '0;
        win_idx    = '0;
        grant_any  = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        rom_addr_d = rom_addr_q;
        if (rst_ni) begin
            if (strict) begin
                gnt_d[REQ_BG] = 1'b1;
                win_idx       = IDX_W'(REQ_BG);
                grant_any     = 1'b1;
            end else if (rr_any) begin
                gnt_d     = rr_gnt;
                win_idx   = rr_idx;
                grant_any = 1'b1;
                rr_ptr_d  = (rr_idx == IDX_W'(N_REQ - 1)) ? RR_LO : rr_idx + IDX_W'(1);
            end
        end
        if (grant_any) begin
            rom_addr_d = req_addr_i[win_idx];
        end
    end

    // Arbitration state: round-robin pointer and the address presented to the ROM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= RR_LO;
            rom_addr_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    // Shift a {valid, one-hot id} tag per cycle; idle cycles insert bubbles, reset drops in-flight reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            rd_data_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[ROM_LAT-1:0], grant_any};
            tag_id_q  <= {tag_id_q[ROM_LAT-1:0], gnt_d};
            rd_data_q <= rom_data_i;
        end
    end

    assign gnt_o      = gnt_d;
    assign rom_addr_o = rom_addr_q;
    assign rd_valid_o = tag_vld_q[ROM_LAT] ? tag_id_q[ROM_LAT] : '0;
    assign rd_data_o  = rd_data_q;
    assign busy_o     = |tag_vld_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - self-checking bench for sprite_rom_arbiter in both priority modes
module tb_sprite_rom_arbiter;
    import sprite_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int DW  = PALETTE_W;

    localparam logic [N-1:0] RR_EXP [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                            4'b0001, 4'b0010, 4'b0100, 4'b1000};
    localparam logic [N-1:0] SP_REQ [6] = '{4'b1110, 4'b1110, 4'b1110, 4'b0001, 4'b0001, 4'b1110};
    localparam logic [N-1:0] SP_EXP [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b0010};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n = 1'b0;
    logic [N-1:0]         req0 = '0, req1 = '0;
    sprite_addr_t [N-1:0] addr0 = '0, addr1 = '0;
    logic [N-1:0]         gnt0, gnt1, rdv0, rdv1;
    sprite_addr_t         rom_addr0, rom_addr1;
    sprite_addr_t         rom_q0 = '0, rom_q1 = '0;
    logic [DW-1:0]        rom_data0, rom_data1, rdd0, rdd1;
    logic                 busy0, busy1;

    // DUT 0 gives the background strict priority; DUT 1 runs everyone in round-robin.
    sprite_rom_arbiter #(.N_REQ(N), .ROM_LAT(LAT), .DATA_W(DW), .BG_PRIO(1)) u_dut_p1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .req_addr_i(addr0), .gnt_o(gnt0),
        .rom_addr_o(rom_addr0), .rom_data_i(rom_data0), .rd_valid_o(rdv0),
        .rd_data_o(rdd0), .busy_o(busy0));

    sprite_rom_arbiter #(.N_REQ(N), .ROM_LAT(LAT), .DATA_W(DW), .BG_PRIO(0)) u_dut_p0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .req_addr_i(addr1), .gnt_o(gnt1),
        .rom_addr_o(rom_addr1), .rom_data_i(rom_data1), .rd_valid_o(rdv1),
        .rd_data_o(rdd1), .busy_o(busy1));

    function automatic logic [DW-1:0] rom_word(input sprite_addr_t a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ {2'b00, a[17:16]};
    endfunction

    // ROM emulation: the arbiter's rom_addr register is the first latency cycle, this is the second.
    always @(posedge clk) rom_q0 <= rom_addr0;
    always @(posedge clk) rom_q1 <= rom_addr1;
    assign rom_data0 = rom_word(rom_q0);
    assign rom_data1 = rom_word(rom_q1);

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic                 st_rst;
    logic [N-1:0]         st_req  [2];
    sprite_addr_t [N-1:0] st_addr [2];

    logic [N-1:0]  obs_gnt [2], obs_rdv [2];
    sprite_addr_t  obs_rom [2];
    logic [DW-1:0] obs_rdd [2];
    logic          obs_busy [2];

    int            ptr [2];
    int            win [2];
    sprite_addr_t  exp_addr [2];
    logic          exp_v   [2][8];
    int            exp_id  [2][8];
    logic [DW-1:0] exp_dat [2][8];
    int            wt [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic sample();
        obs_gnt[0] = gnt0;      obs_gnt[1] = gnt1;
        obs_rdv[0] = rdv0;      obs_rdv[1] = rdv1;
        obs_rom[0] = rom_addr0; obs_rom[1] = rom_addr1;
        obs_rdd[0] = rdd0;      obs_rdd[1] = rdd1;
        obs_busy[0] = busy0;    obs_busy[1] = busy1;
    endtask

    task automatic clear_model(input int d);
        for (int s = 0; s < 8; s++) exp_v[d][s] = 1'b0;
        ptr[d]      = (d == 0) ? 1 : 0;
        exp_addr[d] = '0;
    endtask

    // Reference: strict background, then first requester at or after ptr in the rotation set.
    task automatic model_cycle(input int d);
        logic         prio, pending;
        int           w, k, slot, s2;
        logic [N-1:0] r;
        prio = (d == 0);
        r    = st_req[d];
        slot = cyc % 8;
        win[d] = -1;
        if (!st_rst) begin
            check("rst_gnt", obs_gnt[d], 0);
            check("rst_rdv", obs_rdv[d], 0);
            check("rst_busy", obs_busy[d], 0);
            check("rst_rom", obs_rom[d], 0);
            check("rst_rdd", obs_rdd[d], 0);
            clear_model(d);
            return;
        end
        pending = 1'b0;
        for (int s = 0; s < 8; s++) pending |= exp_v[d][s];
        check("busy", obs_busy[d], pending);
        if (exp_v[d][slot]) begin
            check("rd_valid", obs_rdv[d], 1 << exp_id[d][slot]);
            check("rd_data", obs_rdd[d], exp_dat[d][slot]);
            exp_v[d][slot] = 1'b0;
        end else begin
            check("rd_idle", obs_rdv[d], 0);
        end
        check("rom_addr", obs_rom[d], exp_addr[d]);
        w = -1;
        if (prio && r[0]) begin
            w = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                k = (ptr[d] + i) % N;
                if (w < 0 && r[k] && !(prio && k == 0)) w = k;
            end
            if (w >= 0) begin
                ptr[d] = (w + 1) % N;
                if (prio && ptr[d] == 0) ptr[d] = 1;
            end
        end
        check("gnt", obs_gnt[d], (w >= 0) ? (1 << w) : 0);
        if (w >= 0) begin
            exp_addr[d]       = st_addr[d][w];
            s2                = (cyc + LAT + 1) % 8;
            exp_v[d][s2]      = 1'b1;
            exp_id[d][s2]     = w;
            exp_dat[d][s2]    = rom_word(st_addr[d][w]);
        end
        win[d] = w;
        if (d == 1) begin
            for (int j = 0; j < N; j++) begin
                if (r[j] && obs_gnt[1][j]) begin
                    check("fair", wt[j] < N, 1);
                    wt[j] = 0;
                end else if (r[j]) begin
                    wt[j]++;
                end else begin
                    wt[j] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst_n = st_rst;
        req0  = st_req[0];  req1  = st_req[1];
        addr0 = st_addr[0]; addr1 = st_addr[1];
        @(negedge clk);
        cyc++;
        sample();
        model_cycle(0);
        model_cycle(1);
    endtask

    task automatic rand_stim();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                if (st_req[d][k]) begin
                    if (win[d] == k) begin
                        st_req[d][k]  = 1'($urandom_range(0, 1));
                        st_addr[d][k] = sprite_addr_t'($urandom);
                    end else if ($urandom_range(0, 15) == 0) begin
                        st_req[d][k] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    st_req[d][k]  = 1'b1;
                    st_addr[d][k] = sprite_addr_t'($urandom);
                end
            end
        end
    endtask

    initial begin
        st_rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            st_req[d] = '0;
            for (int k = 0; k < N; k++) st_addr[d][k] = sprite_addr_t'(18'h100 * (k + 1) + d);
            clear_model(d);
        end
        for (int j = 0; j < N; j++) wt[j] = 0;
        repeat (3) tick();

        // Round-robin from reset on DUT 1, strict-priority sequence on DUT 0.
        st_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            st_req[1] = 4'b1111;
            st_req[0] = (i < 6) ? SP_REQ[i] : 4'b0000;
            tick();
            check("rr_seq", obs_gnt[1], RR_EXP[i]);
            if (i < 6) check("prio_seq", obs_gnt[0], SP_EXP[i]);
        end
        st_req[0] = '0; st_req[1] = '0;
        repeat (4) tick();

        // Single read on DUT 1; grant, idle, grant with pointer wrap on DUT 0.
        st_req[1] = 4'b0100; st_addr[1][2] = 18'h12345;
        st_req[0] = 4'b1000;
        tick();
        check("single_gnt", obs_gnt[1], 4'b0100);
        check("wrap_gnt3", obs_gnt[0], 4'b1000);
        st_req[1] = '0; st_req[0] = '0;
        tick();
        check("single_addr", obs_rom[1], 18'h12345);
        st_req[0] = 4'b1010;
        tick();
        check("wrap_gnt1", obs_gnt[0], 4'b0010);
        st_req[0] = '0;
        tick();
        check("single_rdv", obs_rdv[1], 4'b0100);
        check("single_rdd", obs_rdd[1], rom_word(18'h12345));
        repeat (4) tick();

        // Back-to-back alternation between background and requester 1.
        for (int d = 0; d < 2; d++) begin
            st_addr[d][0] = sprite_addr_t'(1707);
            st_addr[d][1] = sprite_addr_t'(78507);
        end
        for (int i = 0; i < 6; i++) begin
            st_req[0] = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            st_req[1] = st_req[0];
            tick();
        end
        st_req[0] = '0; st_req[1] = '0;
        repeat (5) tick();

        // Reset with two reads in flight: outputs clear at once and nothing returns afterwards.
        st_req[0] = 4'b1111; st_req[1] = 4'b1111;
        repeat (3) tick();
        #1;
        rst_n  = 1'b0;
        st_rst = 1'b0;
        #1;
        sample();
        for (int d = 0; d < 2; d++) begin
            check("arst_gnt", obs_gnt[d], 0);
            check("arst_rdv", obs_rdv[d], 0);
            check("arst_busy", obs_busy[d], 0);
            check("arst_rom", obs_rom[d], 0);
            check("arst_rdd", obs_rdd[d], 0);
        end
        repeat (2) tick();
        st_req[0] = '0; st_req[1] = '0;
        st_rst = 1'b1;
        for (int j = 0; j < N; j++) wt[j] = 0;
        repeat (6) tick();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            rand_stim();
            tick();
        end
        st_req[0] = '0; st_req[1] = '0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
